// File: rtl/game_sprite_display.sv
// Sprite overlay pixel generator: position shadowed at frame_start, bitmap/colour lookup, per-frame visibility.
// Latency 2 cycles from (x,y,display_on) to rgb_en/rgb; accepts one pixel every cycle, no backpressure.
module game_sprite_display #(
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int RGB_WIDTH     = 3,
    parameter logic [RGB_WIDTH-1:0] DEFAULT_RGB = 3'b100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             display_on,
    input  logic [w_x-1:0]                   x,
    input  logic [w_y-1:0]                   y,
    input  logic                             frame_start,
    input  logic [w_x-1:0]                   sprite_x,
    input  logic [w_y-1:0]                   sprite_y,
    input  logic                             bmp_write,
    input  logic [$clog2(SPRITE_HEIGHT)-1:0] bmp_row,
    input  logic [SPRITE_WIDTH-1:0]          bmp_data,
    input  logic                             rgb_write,
    input  logic [RGB_WIDTH-1:0]             rgb_write_data,
    output logic                             rgb_en,
    output logic [RGB_WIDTH-1:0]             rgb,
    output logic                             sprite_visible
);

    localparam int CW = $clog2(SPRITE_WIDTH);
    localparam int RW = $clog2(SPRITE_HEIGHT);

    localparam logic [w_x:0]    SPAN_X = (w_x+1)'(SPRITE_WIDTH);
    localparam logic [w_y:0]    SPAN_Y = (w_y+1)'(SPRITE_HEIGHT);
    localparam logic [RW:0]     ROWS   = (RW+1)'(SPRITE_HEIGHT);
    localparam logic [CW-1:0]   LAST_COL = CW'(SPRITE_WIDTH - 1);

    logic [w_x-1:0]          pos_x_q, pos_x_d;
    logic [w_y-1:0]          pos_y_q, pos_y_d;
    logic                    in_box_q, in_box_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    rgb_en_q, rgb_en_d;
    logic [RGB_WIDTH-1:0]    rgb_q, rgb_d;
    logic [RGB_WIDTH-1:0]    colour_q, colour_d;
    logic                    seen_q, seen_d;
    logic                    visible_q, visible_d;
    logic [SPRITE_WIDTH-1:0] bitmap_q [SPRITE_HEIGHT];

    logic [w_x:0]            x_ext, lo_x, hi_x;
    logic [w_y:0]            y_ext, lo_y, hi_y;
    logic [SPRITE_WIDTH-1:0] row_bits;
    logic [CW-1:0]           bit_idx;
    logic                    bmp_wr_ok;

    // One extra bit on the bounds keeps pos+SPRITE size from wrapping near the screen edge.
    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};
    assign lo_x  = {1'b0, pos_x_q};
    assign lo_y  = {1'b0, pos_y_q};
    assign hi_x  = lo_x + SPAN_X;
    assign hi_y  = lo_y + SPAN_Y;

    assign row_bits  = bitmap_q[row_q];
    assign bit_idx   = LAST_COL - col_q;
    assign bmp_wr_ok = bmp_write && ({1'b0, bmp_row} < ROWS);

    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        seen_d    = seen_q | rgb_en_q;
        visible_d = visible_q;
        colour_d  = rgb_write ? rgb_write_data : colour_q;

        in_box_d = display_on
                 && (x_ext >= lo_x) && (x_ext < hi_x)
                 && (y_ext >= lo_y) && (y_ext < hi_y);
        col_d    = x[CW-1:0] - pos_x_q[CW-1:0];
        row_d    = y[RW-1:0] - pos_y_q[RW-1:0];

        rgb_en_d = in_box_q & row_bits[bit_idx];
        rgb_d    = rgb_en_d ? colour_q : '0;

        if (frame_start) begin
            pos_x_d   = sprite_x;
            pos_y_d   = sprite_y;
            visible_d = seen_q | rgb_en_q;
            seen_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            in_box_q  <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            rgb_en_q  <= 1'b0;
            rgb_q     <= '0;
            colour_q  <= DEFAULT_RGB;
            seen_q    <= 1'b0;
            visible_q <= 1'b0;
            for (int r = 0; r < SPRITE_HEIGHT; r++) begin
                bitmap_q[r] <= '0;
            end
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            in_box_q  <= in_box_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rgb_en_q  <= rgb_en_d;
            rgb_q     <= rgb_d;
            colour_q  <= colour_d;
            seen_q    <= seen_d;
            visible_q <= visible_d;
            // Stage 2 reads bitmap_q this same edge, so a same-cycle write is seen one pixel later.
            if (bmp_wr_ok) begin
                bitmap_q[bmp_row] <= bmp_data;
            end
        end
    end

    assign rgb_en         = rgb_en_q;
    assign rgb            = rgb_q;
    assign sprite_visible = visible_q;

endmodule

// File: tb/tb_game_sprite_display.sv
// Bench for game_sprite_display: behavioural pixel model compared every cycle, plus literal anchors.
module tb_game_sprite_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       display_on;
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_start;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       bmp_write;
    logic [2:0] bmp_row;
    logic [7:0] bmp_data;
    logic       rgb_write;
    logic [2:0] rgb_write_data;
    logic       rgb_en;
    logic [2:0] rgb;
    logic       sprite_visible;

    int checks = 0;
    int passes = 0;

    game_sprite_display dut (
        .clk            (clk),
        .rst            (rst),
        .display_on     (display_on),
        .x              (x),
        .y              (y),
        .frame_start    (frame_start),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .bmp_write      (bmp_write),
        .bmp_row        (bmp_row),
        .bmp_data       (bmp_data),
        .rgb_write      (rgb_write),
        .rgb_write_data (rgb_write_data),
        .rgb_en         (rgb_en),
        .rgb            (rgb),
        .sprite_visible (sprite_visible)
    );

    always #5 clk = ~clk;

    // Reference: a pixel is judged against the shadow position it saw when presented,
    // and against the bitmap/colour in force one edge later.
    typedef struct packed {
        bit on;
        int px_x;
        int px_y;
        int sh_x;
        int sh_y;
    } pix_t;

    pix_t       pend;
    logic [7:0] m_bmp [8];
    logic [2:0] m_colour;
    int         m_px, m_py;
    bit         m_seen;
    logic       e_en;
    logic [2:0] e_rgb;
    logic       e_vis;

    function automatic logic opaque(input pix_t p);
        int dx, dy;
        logic [2:0] r, c;
        dx = p.px_x - p.sh_x;
        dy = p.px_y - p.sh_y;
        if (!p.on || dx < 0 || dx > 7 || dy < 0 || dy > 7) return 1'b0;
        r = 3'(dy);
        c = 3'(7 - dx);
        return m_bmp[r][c];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            m_px     <= 0;
            m_py     <= 0;
            m_colour <= 3'b100;
            m_seen   <= 1'b0;
            e_en     <= 1'b0;
            e_rgb    <= 3'd0;
            e_vis    <= 1'b0;
            for (int r = 0; r < 8; r++) m_bmp[r] <= 8'h00;
        end else begin
            e_en  <= opaque(pend);
            e_rgb <= opaque(pend) ? m_colour : 3'd0;
            pend.on   <= display_on;
            pend.px_x <= int'(x);
            pend.px_y <= int'(y);
            pend.sh_x <= m_px;
            pend.sh_y <= m_py;
            if (frame_start) begin
                m_px   <= int'(sprite_x);
                m_py   <= int'(sprite_y);
                e_vis  <= m_seen | e_en;
                m_seen <= 1'b0;
            end else if (e_en) begin
                m_seen <= 1'b1;
            end
            if (bmp_write) m_bmp[bmp_row] <= bmp_data;
            if (rgb_write) m_colour <= rgb_write_data;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One pixel per call: drive, wait one cycle, compare DUT against the model.
    task automatic px(input logic d, input int xx, input int yy, input logic fs);
        display_on  = d;
        x           = 10'(xx);
        y           = 9'(yy);
        frame_start = fs;
        @(negedge clk);
        bmp_write   = 1'b0;
        rgb_write   = 1'b0;
        frame_start = 1'b0;
        display_on  = 1'b0;
        if (!rst) begin
            chk("model_rgb_en", 8'(rgb_en), 8'(e_en));
            chk("model_rgb", 8'(rgb), 8'(e_rgb));
            chk("model_visible", 8'(sprite_visible), 8'(e_vis));
        end
    endtask

    initial begin
        int xx, yy;
        logic fs;
        rst = 1'b1;
        display_on = 0; x = 0; y = 0; frame_start = 0;
        sprite_x = 0; sprite_y = 0;
        bmp_write = 0; bmp_row = 0; bmp_data = 0;
        rgb_write = 0; rgb_write_data = 0;
        repeat (3) @(negedge clk);
        chk("reset_rgb_en", 8'(rgb_en), 8'd0);
        chk("reset_rgb", 8'(rgb), 8'd0);
        chk("reset_visible", 8'(sprite_visible), 8'd0);
        rst = 1'b0;

        // Full bitmap, sprite at (100,50)
        for (int r = 0; r < 8; r++) begin
            bmp_write = 1'b1; bmp_row = 3'(r); bmp_data = 8'hFF;
            px(0, 0, 0, 0);
        end
        sprite_x = 10'd100; sprite_y = 9'd50;
        px(0, 0, 0, 1);
        px(1, 100, 50, 0);
        px(0, 0, 0, 0);
        chk("topleft_en", 8'(rgb_en), 8'd1);
        chk("topleft_rgb", 8'(rgb), 8'd4);
        px(1, 99, 50, 0);
        px(1, 108, 50, 0);
        chk("left_of_box", 8'(rgb_en), 8'd0);
        px(1, 100, 58, 0);
        chk("right_of_box", 8'(rgb_en), 8'd0);
        px(0, 0, 0, 0);
        chk("below_box", 8'(rgb_en), 8'd0);

        // Row 0 pattern, back-to-back alignment
        bmp_write = 1'b1; bmp_row = 3'd0; bmp_data = 8'b1000_0001;
        px(0, 0, 0, 0);
        px(1, 100, 50, 0);
        px(1, 101, 50, 0);
        chk("row0_col0", 8'(rgb_en), 8'd1);
        px(1, 107, 50, 0);
        chk("row0_col1", 8'(rgb_en), 8'd0);
        px(0, 0, 0, 0);
        chk("row0_col7", 8'(rgb_en), 8'd1);

        // Shadow frozen until frame_start
        sprite_x = 10'd200;
        px(1, 100, 51, 0);
        px(1, 200, 51, 0);
        chk("frozen_old_hit", 8'(rgb_en), 8'd1);
        px(0, 0, 0, 0);
        chk("frozen_new_miss", 8'(rgb_en), 8'd0);
        px(1, 100, 52, 1);
        px(1, 200, 52, 0);
        chk("fs_cycle_old_shadow", 8'(rgb_en), 8'd1);
        chk("visible_after_hits", 8'(sprite_visible), 8'd1);
        px(1, 100, 53, 0);
        chk("new_pos_hit", 8'(rgb_en), 8'd1);
        px(0, 0, 0, 0);
        chk("old_pos_miss", 8'(rgb_en), 8'd0);

        // Visibility over a hit frame then an empty frame
        px(0, 0, 0, 1);
        chk("visible_hit_frame", 8'(sprite_visible), 8'd1);
        repeat (3) px(0, 0, 0, 0);
        px(0, 0, 0, 1);
        chk("visible_empty_frame", 8'(sprite_visible), 8'd0);

        // Bottom-right screen edge
        sprite_x = 10'd632; sprite_y = 9'd472;
        px(0, 0, 0, 1);
        px(1, 639, 479, 0);
        px(1, 0, 0, 0);
        chk("edge_hit", 8'(rgb_en), 8'd1);
        px(0, 0, 0, 0);
        chk("edge_no_wrap", 8'(rgb_en), 8'd0);

        // Same-cycle bitmap and colour writes
        sprite_x = 10'd100; sprite_y = 9'd50;
        px(0, 0, 0, 1);
        px(1, 100, 50, 0);
        bmp_write = 1'b1; bmp_row = 3'd0; bmp_data = 8'h00;
        px(1, 100, 50, 0);
        chk("bmp_write_old", 8'(rgb_en), 8'd1);
        px(0, 0, 0, 0);
        chk("bmp_write_new", 8'(rgb_en), 8'd0);
        px(1, 100, 51, 0);
        rgb_write = 1'b1; rgb_write_data = 3'b011;
        px(1, 100, 51, 0);
        chk("rgb_write_old", 8'(rgb), 8'd4);
        px(0, 0, 0, 0);
        chk("rgb_write_new", 8'(rgb), 8'd3);

        // Asynchronous reset with a hit in flight
        px(1, 100, 51, 0);
        px(1, 101, 51, 0);
        chk("pre_reset_hit", 8'(rgb_en), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 8'(rgb_en), 8'd0);
        chk("async_rst_rgb", 8'(rgb), 8'd0);
        chk("async_rst_visible", 8'(sprite_visible), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        px(1, 0, 0, 0);
        px(0, 0, 0, 0);
        chk("post_rst_blank_bitmap", 8'(rgb_en), 8'd0);

        // Randomized traffic around the sprite
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bmp_write = 1'b1;
                bmp_row   = 3'($urandom_range(0, 7));
                bmp_data  = 8'($urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                rgb_write      = 1'b1;
                rgb_write_data = 3'($urandom);
            end
            if ($urandom_range(0, 29) == 0) begin
                sprite_x = 10'($urandom_range(0, 632));
                sprite_y = 9'($urandom_range(0, 472));
            end
            fs = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) != 0) begin
                xx = m_px + int'($urandom_range(0, 13)) - 3;
                yy = m_py + int'($urandom_range(0, 13)) - 3;
            end else begin
                xx = int'($urandom_range(0, 639));
                yy = int'($urandom_range(0, 479));
            end
            if (xx < 0) xx = 0;
            if (xx > 639) xx = 639;
            if (yy < 0) yy = 0;
            if (yy > 479) yy = 479;
            px($urandom_range(0, 9) != 0, xx, yy, fs);
        end
        px(0, 0, 0, 0);
        px(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
